// File: rtl/abr_params_pkg.sv
// Shared ML-DSA sizing constants and the t0 bit-buffer FSM state type.
package abr_params_pkg;

    localparam int unsigned MLDSA_D           = 13;
    localparam int unsigned MLDSA_N           = 256;
    localparam int unsigned T0_WORDS_PER_POLY = (MLDSA_N * MLDSA_D) / 64;
    localparam int unsigned T0_BEATS_PER_POLY = MLDSA_N / 8;

    typedef enum logic [1:0] {
        T0_IDLE = 2'd0,
        T0_RUN  = 2'd1,
        T0_DONE = 2'd2
    } t0_bitbuf_state_e;

endpackage

// File: rtl/abr_bit_shiftbuf.sv
// Generic push-W / pop-P right-shifting bit buffer with a fill counter.
// Pop shifts out the low P bits first; a same-cycle push lands at the post-pop fill level.
module abr_bit_shiftbuf #(
    parameter int unsigned W     = 64,
    parameter int unsigned P     = 104,
    parameter int unsigned DEPTH = 168,
    parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic             push_i,
    input  logic [W-1:0]     din_i,
    input  logic             pop_i,
    output logic [P-1:0]     dout_o,
    output logic [CNT_W-1:0] cnt_o
);

    logic [DEPTH-1:0] sbuf_q, sbuf_d, sbuf_sh;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_sh;

    // Bits above cnt are always zero, so an OR is enough to insert new data.
    always_comb begin
        sbuf_sh = pop_i ? (sbuf_q >> P) : sbuf_q;
        cnt_sh  = pop_i ? (cnt_q - CNT_W'(P)) : cnt_q;
        sbuf_d  = sbuf_sh;
        cnt_d   = cnt_sh;
        if (push_i) begin
            sbuf_d = sbuf_sh | ({{(DEPTH - W){1'b0}}, din_i} << cnt_sh);
            cnt_d  = cnt_sh + CNT_W'(W);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sbuf_q <= '0;
            cnt_q  <= '0;
        end else if (clr_i) begin
            sbuf_q <= '0;
            cnt_q  <= '0;
        end else begin
            sbuf_q <= sbuf_d;
            cnt_q  <= cnt_d;
        end
    end

    assign dout_o = sbuf_q[P-1:0];
    assign cnt_o  = cnt_q;

endmodule

// File: rtl/skdecode_t0_bitbuf.sv
// Realigns 64-bit packed t0 words into 8 x 13-bit fields per beat for the t0 unpack lanes.
// Optional sticky protocol-error flag: define SKDECODE_T0_BITBUF_CHK_EN.
module skdecode_t0_bitbuf #(
    parameter int unsigned IN_W    = 64,
    parameter int unsigned MLDSA_D = 13,
    parameter int unsigned LANES   = 8,
    parameter int unsigned MLDSA_N = 256,
    parameter int unsigned POLY_W  = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     zeroize,
    input  logic                     start_i,
    input  logic [POLY_W-1:0]        num_poly_i,
    input  logic                     sub_mode_i,
    input  logic [IN_W-1:0]          data_i,
    input  logic                     data_valid_i,
    output logic                     data_ready_o,
    output logic [LANES*MLDSA_D-1:0] coeff_o,
    output logic                     enable_o,
    output logic                     sub_o,
    output logic                     busy_o,
    output logic                     done_o,
    output logic                     err_o
);
    import abr_params_pkg::*;

    localparam int unsigned POP_W = LANES * MLDSA_D;
    localparam int unsigned BUF_W = POP_W + IN_W;
    localparam int unsigned CNT_W = $clog2(BUF_W + 1);
    localparam int unsigned WPP   = (MLDSA_N * MLDSA_D) / IN_W;
    localparam int unsigned BPP   = MLDSA_N / LANES;
    localparam int unsigned MAXP  = (1 << POLY_W) - 1;
    localparam int unsigned WB_W  = $clog2(WPP * MAXP + 1);
    localparam int unsigned BB_W  = $clog2(BPP * MAXP + 1);

    t0_bitbuf_state_e   state_q, state_d;
    logic [WB_W-1:0]    wbud_q, wbud_d;
    logic [BB_W-1:0]    bbud_q, bbud_d;
    logic               sub_q, sub_d;
    logic [POP_W-1:0]   coeff_q, coeff_d;
    logic               en_q;
    logic [CNT_W-1:0]   cnt;
    logic [POP_W-1:0]   pop_data;
    logic [POLY_W-1:0]  np;
    logic               run, push, pop;

    assign run  = (state_q == T0_RUN);
    assign push = run && data_valid_i && (wbud_q != '0);
    assign pop  = run && (cnt >= CNT_W'(POP_W));
    assign np   = (num_poly_i == '0) ? POLY_W'(1) : num_poly_i;

    abr_bit_shiftbuf #(
        .W     (IN_W),
        .P     (POP_W),
        .DEPTH (BUF_W),
        .CNT_W (CNT_W)
    ) u_buf (
        .clk    (clk),
        .rst_n  (reset_n),
        .clr_i  (zeroize),
        .push_i (push),
        .din_i  (data_i),
        .pop_i  (pop),
        .dout_o (pop_data),
        .cnt_o  (cnt)
    );

    always_comb begin
        state_d = state_q;
        wbud_d  = wbud_q;
        bbud_d  = bbud_q;
        sub_d   = sub_q;
        coeff_d = coeff_q;
        if (push) wbud_d = wbud_q - WB_W'(1);
        if (pop) begin
            bbud_d  = bbud_q - BB_W'(1);
            coeff_d = pop_data;
        end
        case (state_q)
            T0_IDLE: begin
                if (start_i) begin
                    state_d = T0_RUN;
                    wbud_d  = WB_W'(WPP) * WB_W'(np);
                    bbud_d  = BB_W'(BPP) * BB_W'(np);
                    sub_d   = sub_mode_i;
                end
            end
            T0_RUN:  if (pop && (bbud_q == BB_W'(1))) state_d = T0_DONE;
            T0_DONE: state_d = T0_IDLE;
            default: state_d = T0_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= T0_IDLE;
            wbud_q  <= '0;
            bbud_q  <= '0;
            sub_q   <= 1'b0;
            coeff_q <= '0;
            en_q    <= 1'b0;
        end else if (zeroize) begin
            state_q <= T0_IDLE;
            wbud_q  <= '0;
            bbud_q  <= '0;
            sub_q   <= 1'b0;
            coeff_q <= '0;
            en_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            wbud_q  <= wbud_d;
            bbud_q  <= bbud_d;
            sub_q   <= sub_d;
            coeff_q <= coeff_d;
            en_q    <= pop;
        end
    end

    assign data_ready_o = run && (wbud_q != '0);
    assign coeff_o      = coeff_q;
    assign enable_o     = en_q;
    assign sub_o        = sub_q;
    assign busy_o       = (state_q != T0_IDLE);
    assign done_o       = (state_q == T0_DONE);

`ifdef SKDECODE_T0_BITBUF_CHK_EN
    logic err_q;

    // Any valid word that cannot be accepted is a protocol error and is dropped.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)     err_q <= 1'b0;
        else if (zeroize) err_q <= 1'b0;
        else              err_q <= err_q | (data_valid_i && !data_ready_o);
    end

    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_skdecode_t0_bitbuf.sv
// Directed self-checking bench for skdecode_t0_bitbuf using a 13-bit counting stream.
module tb_skdecode_t0_bitbuf;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         zeroize = 1'b0;
    logic         start_i = 1'b0;
    logic [3:0]   num_poly_i = '0;
    logic         sub_mode_i = 1'b0;
    logic [63:0]  data_i = '0;
    logic         data_valid_i = 1'b0;
    logic         data_ready_o;
    logic [103:0] coeff_o;
    logic         enable_o, sub_o, busy_o, done_o, err_o;

    int n_chk = 0;
    int n_pass = 0;
    int beat_cnt = 0;
    int done_cnt = 0;
    int done_at_beat = -1;
    logic done_with_en = 1'b0;
    logic exp_sub = 1'b0;
    logic exp_err;

    skdecode_t0_bitbuf #(
        .IN_W    (64),
        .MLDSA_D (13),
        .LANES   (8),
        .MLDSA_N (256),
        .POLY_W  (4)
    ) u_dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .zeroize      (zeroize),
        .start_i      (start_i),
        .num_poly_i   (num_poly_i),
        .sub_mode_i   (sub_mode_i),
        .data_i       (data_i),
        .data_valid_i (data_valid_i),
        .data_ready_o (data_ready_o),
        .coeff_o      (coeff_o),
        .enable_o     (enable_o),
        .sub_o        (sub_o),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .err_o        (err_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Stream bit p belongs to field p/13, bit p%13; field j carries value j.
    function automatic logic [63:0] stream_word(input int unsigned w);
        logic [63:0] r;
        logic [12:0] fv;
        int unsigned pos;
        for (int unsigned i = 0; i < 64; i++) begin
            pos  = 64 * w + i;
            fv   = 13'(pos / 13);
            r[i] = fv[pos % 13];
        end
        return r;
    endfunction

    function automatic logic [103:0] exp_beat(input int unsigned b);
        logic [103:0] r;
        for (int unsigned k = 0; k < 8; k++) r[13*k +: 13] = 13'(8 * b + k);
        return r;
    endfunction

    always @(negedge clk) begin
        if (reset_n) begin
            if (enable_o) begin
                check("beat", coeff_o, exp_beat(beat_cnt));
                check("sub_at_beat", sub_o, exp_sub);
                beat_cnt++;
            end
            if (done_o) begin
                done_cnt++;
                done_at_beat = beat_cnt;
                done_with_en = enable_o;
            end
        end
    end

    task automatic start_job(input int np, input logic sub);
        @(posedge clk); #1;
        num_poly_i = 4'(np);
        sub_mode_i = sub;
        start_i = 1'b1;
        beat_cnt = 0;
        done_cnt = 0;
        done_at_beat = -1;
        done_with_en = 1'b0;
        exp_sub = sub;
        @(posedge clk); #1;
        start_i = 1'b0;
        num_poly_i = '0;
        sub_mode_i = ~sub;
    endtask

    task automatic send_word(input logic [63:0] d);
        bit ok;
        ok = 1'b0;
        data_i = d;
        data_valid_i = 1'b1;
        for (int unsigned i = 0; i < 64; i++) begin
            @(negedge clk);
            if (data_ready_o) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk); #1;
        if (!ok) check("ready_timeout", 1'b0, 1'b1);
    endtask

    task automatic feed(input int nwords, input bit gap, input int mid_start, input int stop_beat);
        for (int w = 0; w < nwords; w++) begin
            if (stop_beat >= 0 && beat_cnt >= stop_beat) break;
            send_word(stream_word(w));
            if (gap || w == mid_start) begin
                data_valid_i = 1'b0;
                if (w == mid_start) begin
                    start_i = 1'b1;
                    num_poly_i = 4'd3;
                end
                @(posedge clk); #1;
                start_i = 1'b0;
                num_poly_i = '0;
            end
        end
        data_valid_i = 1'b0;
    endtask

    task automatic wait_done();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (done_cnt > 0) begin
                ok = 1'b1;
                break;
            end
        end
        check("done_seen", ok, 1'b1);
        @(negedge clk);
        check("busy_after_done", busy_o, 1'b0);
        check("done_pulse_width", done_o, 1'b0);
        repeat (4) @(negedge clk);
    endtask

    task automatic post_job(input int exp_beats);
        check("beat_total", beat_cnt, exp_beats);
        check("done_count", done_cnt, 1);
        check("done_beat", done_at_beat, exp_beats);
        check("done_with_en", done_with_en, 1'b1);
        check("cnt_end", u_dut.u_buf.cnt_q, 0);
        check("ready_idle", data_ready_o, 1'b0);
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_enable"}, enable_o, 1'b0);
        check({tag, "_coeff"}, coeff_o, '0);
        check({tag, "_sub"}, sub_o, 1'b0);
        check({tag, "_busy"}, busy_o, 1'b0);
        check({tag, "_done"}, done_o, 1'b0);
        check({tag, "_ready"}, data_ready_o, 1'b0);
        check({tag, "_err"}, err_o, 1'b0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_cleared("reset");
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(negedge clk);
        check_cleared("post_reset");

        // Single polynomial, back-to-back words.
        start_job(1, 1'b0);
        feed(52, 1'b0, -1, -1);
        wait_done();
        post_job(32);
        check("err_clean", err_o, 1'b0);

        // Same stream with valid bubbles.
        start_job(1, 1'b0);
        feed(52, 1'b1, -1, -1);
        wait_done();
        post_job(32);

        // Eight polynomials in subtraction mode.
        start_job(8, 1'b1);
        feed(416, 1'b0, -1, -1);
        wait_done();
        post_job(256);

        // Zeroize mid-job, then a fresh job restarts at field 0.
        start_job(1, 1'b1);
        feed(52, 1'b0, -1, 11);
        zeroize = 1'b1;
        @(posedge clk); #1;
        zeroize = 1'b0;
        @(negedge clk);
        check_cleared("zeroize");
        check("zeroize_cnt", u_dut.u_buf.cnt_q, 0);
        start_job(1, 1'b0);
        feed(52, 1'b0, -1, -1);
        wait_done();
        post_job(32);

        // num_poly 0 runs one polynomial; start during RUN is ignored.
        start_job(0, 1'b0);
        feed(52, 1'b0, 20, -1);
        wait_done();
        post_job(32);

        // A 53rd valid word while RUN with an exhausted budget.
        start_job(1, 1'b0);
        feed(52, 1'b0, -1, -1);
        data_i = stream_word(52);
        data_valid_i = 1'b1;
        @(posedge clk); #1;
        data_valid_i = 1'b0;
        wait_done();
        post_job(32);
`ifdef SKDECODE_T0_BITBUF_CHK_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        check("err_after_overrun", err_o, exp_err);
        repeat (5) @(negedge clk);
        check("err_sticky", err_o, exp_err);
        @(posedge clk); #1;
        zeroize = 1'b1;
        @(posedge clk); #1;
        zeroize = 1'b0;
        @(negedge clk);
        check("err_zeroized", err_o, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
